mips_cpu_muldiv_seq: RTL
========================

Name: mips_cpu_muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the architectural HI/LO registers of the MIPS core.
- Accepts MULT, MULTU, DIV and DIVU from the decode stage and runs a 32-iteration shift-add or restoring-divide datapath.
- Raises busy so the pipeline stalls, then commits HI/LO and pulses done.
- Also services MTHI/MTLO writes and provides HI/LO read values for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a mult/div; sampled only in IDLE.
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- flush  input  1  synchronous abort of an in-flight operation.
- mthi  input  1  write a into HI.
- mtlo  input  1  write a into LO.
- busy  output  1  operation in flight; the CPU stalls any HI/LO access or new mult/div while high.
- done  output  1  one-cycle pulse when HI/LO have been committed.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

Behaviour:
- Reset (async, reset_n low): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. Reset mid-operation discards the operation; HI/LO go to 0.
- States are IDLE, CALC and FIX.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Latch the result sign flags: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - Go to CALC with counter=0; busy=1 from E0.
- CALC: one iteration per edge, E1..E32; counter increments and wraps 31 -> FIX.
  - Multiply: 64-bit product register, shift-add on the LSB of the multiplier.
  - Divide: restoring; shift the remainder left, subtract the divisor, keep the result if non-negative, shift in the quotient bit.
- FIX at E33:
  - Apply two's-complement negation per the sign flags (signed ops only).
  - Write HI/LO. MULT/MULTU: HI=product[63:32], LO=product[31:0]. DIV/DIVU: LO=quotient, HI=remainder.
  - busy=0 and done=1 for exactly one cycle after E33; return to IDLE.
- Latency: busy is high for exactly 33 cycles; done appears 33 edges after the start edge. Latency is fixed regardless of operand values.
- Divide by zero (b=0, DIV or DIVU): same 33-cycle latency; result HI=a (original, unsigned-interpreted bits), LO=32'hFFFF_FFFF.
- Signed overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0 (wraps, no trap).
- start while busy: ignored. The CPU guarantees it never issues one, and the bench checks there is no state corruption.
- mthi/mtlo in IDLE: the register updates at the next edge. Both may be asserted together, and both are written.
- mthi/mtlo while busy: ignored.
- start together with mthi/mtlo in IDLE: start wins; the writes are dropped.
- flush:
  - In CALC or FIX: return to IDLE at the next edge, busy=0, no done, HI/LO unchanged.
  - In IDLE: no effect; it also suppresses a coincident start.
- hi and lo are registered outputs, stable throughout CALC; they show the previous values until FIX commits.
- done never asserts together with busy.

Test Plan:
- Reset: drive reset_n low mid-CALC of a MULTU -> busy=0, done=0, hi=0, lo=0 immediately, without waiting for an edge.
- MULT a=0xFFFF_FFFD (-3), b=5 -> after 33 edges done=1, hi=0xFFFF_FFFF, lo=0xFFFF_FFF1; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- Signed and unsigned divides:
  - DIV a=0xFFFF_FFF9 (-7), b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
  - DIVU a=100, b=7 -> lo=14, hi=2.
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- Divide by zero, start and flush collisions:
  - DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFF_FFFF after 33 cycles.
  - start pulsed again mid-CALC -> the result is unaffected.
  - flush at cycle 10 -> no done, HI/LO retain prior values.
- MTHI/MTLO:
  - mthi a=0xAAAA_0000, then mtlo a=0x5555 in IDLE -> hi=0xAAAA_0000, lo=0x5555.
  - mthi while busy -> ignored; the final hi equals the op result.
  - start together with mtlo -> the op runs and lo equals the op result.

Source files
------------

// File: rtl/mips_cpu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, also serving MTHI/MTLO and MFHI/MFLO reads.
// Latency fixed at 33 cycles of busy then a one-cycle done; busy is the only stall, flush aborts without commit.
module mips_cpu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 divz_q, divz_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 op_signed;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_new;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Operand conditioning: signed ops run on magnitudes, sign fixed up at the end.
    always_comb begin
        op_signed = ~op[0];
        abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
        abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;
    end

    // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = (rem_sh >= {1'b0, opb_q});
        rem_new  = div_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
        acc_step = is_div_q ? {rem_new, acc_q[WIDTH-2:0], div_ge}
                            : {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Divide by zero leaves rem = dividend magnitude, so only the quotient needs forcing.
    always_comb begin
        prod_fix = qneg_q ? -acc_q : acc_q;
        quo_fix  = divz_q ? '1 : (qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        divz_d   = divz_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    qneg_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d   = op_signed & a[WIDTH-1];
                    divz_d   = op[1] & (b == '0);
                    opb_d    = op[1] ? abs_b : abs_a;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                end else if (!start) begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_step;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            divz_q   <= divz_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
